// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bit positions, MEM-stage FSM states, default datapath width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    localparam int DW_DEF = 32;

    // Bit positions inside ctlwb (WB bundle) and ctlm (MEM bundle)
    localparam int REGWRITE = 1;
    localparam int MEMTOREG = 0;
    localparam int MEMREAD  = 1;
    localparam int MEMWRITE = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register with synchronous clear and bubble insert.
// Latency: 1 cycle, d to q.
// Backpressure: none; bubble=1 loads all-zero fields instead of d.
module mem_wb_latch
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bubble,
    input  logic [1:0]    ctlwb_d,
    input  logic [DW-1:0] rdata_d,
    input  logic [DW-1:0] alu_d,
    input  logic [4:0]    dst_d,
    output logic [1:0]    ctlwb_q,
    output logic [DW-1:0] rdata_q,
    output logic [DW-1:0] alu_q,
    output logic [4:0]    dst_q
);

    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            ctlwb_q <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            dst_q   <= '0;
        end else begin
            ctlwb_q <= ctlwb_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            dst_q   <= dst_d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: runs loads/stores on a req/ready + rvalid data memory; optional watchdog under MEM_TIMEOUT_EN.
// Latency: 1 cycle for non-memory ops; memory ops take 2 stall cycles plus ready/rvalid wait.
// Backpressure: combinational stall freezes upstream while an access is open; MEM/WB gets bubbles meanwhile.
module mem_access_unit
    import pipe_pkg::*;
#(
    parameter int DW             = DW_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    ctlwb_in,
    input  logic [1:0]    ctlm_in,
    input  logic [DW-1:0] alu_result_in,
    input  logic [DW-1:0] rdata2_in,
    input  logic [4:0]    muxout_in,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ready,
    input  logic          dmem_rvalid,
    input  logic [DW-1:0] dmem_rdata,
    output logic          stall,
    output logic [1:0]    ctlwb_out,
    output logic [DW-1:0] read_data_out,
    output logic [DW-1:0] alu_result_out,
    output logic [4:0]    muxout_out,
    output logic          mem_err
);

    mem_state_e    state_q, state_nxt;
    logic [DW-1:0] cap_q;
    logic          is_acc, is_load, req_ok, wait_ok, done_ok, cap_en;
    logic          wd_expire, timed_out;
    logic          wb_bubble;
    logic [1:0]    wb_ctl;
    logic [DW-1:0] wb_rdata;

    // A set MemRead wins over MemWrite: the access is a load
    assign is_acc  = ctlm_in[MEMREAD] | ctlm_in[MEMWRITE];
    assign is_load = ctlm_in[MEMREAD];

    assign dmem_we    = ctlm_in[MEMWRITE] & ~ctlm_in[MEMREAD];
    assign dmem_addr  = alu_result_in;
    assign dmem_wdata = rdata2_in;

    assign req_ok  = (state_q == ST_REQ) && dmem_ready && (!is_load || dmem_rvalid);
    assign wait_ok = (state_q == ST_WAIT) && dmem_rvalid;
    assign done_ok = req_ok || wait_ok;
    assign cap_en  = (req_ok && is_load) || wait_ok;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wd_cnt_q;
    logic       to_q;

    assign wd_expire = ((state_q == ST_REQ) || (state_q == ST_WAIT)) &&
                       (wd_cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || state_q == ST_IDLE) begin
            wd_cnt_q <= '0;
        end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
        end
    end

    // Marks the DONE cycle that was reached by the watchdog rather than the memory
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_q <= 1'b0;
        end else begin
            to_q <= wd_expire && !done_ok;
        end
    end

    assign timed_out = to_q;
    assign mem_err   = (state_q == ST_DONE) && to_q;
`else
    assign wd_expire = 1'b0;
    assign timed_out = 1'b0;
    assign mem_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (is_acc) state_nxt = ST_REQ;
            ST_REQ: begin
                if (req_ok)          state_nxt = ST_DONE;
                else if (wd_expire)  state_nxt = ST_DONE;
                else if (dmem_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: if (wait_ok || wd_expire) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dmem_req  = 1'b0;
        stall     = 1'b0;
        wb_bubble = 1'b0;
        wb_ctl    = ctlwb_in;
        wb_rdata  = '0;
        case (state_q)
            ST_IDLE: begin
                stall     = is_acc;
                wb_bubble = is_acc;
            end
            ST_REQ: begin
                dmem_req  = 1'b1;
                stall     = 1'b1;
                wb_bubble = 1'b1;
            end
            ST_WAIT: begin
                stall     = 1'b1;
                wb_bubble = 1'b1;
            end
            ST_DONE: begin
                wb_rdata = is_load ? cap_q : '0;
                if (timed_out) begin
                    wb_ctl   = '0;
                    wb_rdata = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_q <= '0;
        end else if (cap_en) begin
            cap_q <= dmem_rdata;
        end
    end

    mem_wb_latch #(.DW(DW)) u_mem_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble  (wb_bubble),
        .ctlwb_d (wb_ctl),
        .rdata_d (wb_rdata),
        .alu_d   (alu_result_in),
        .dst_d   (muxout_in),
        .ctlwb_q (ctlwb_out),
        .rdata_q (read_data_out),
        .alu_q   (alu_result_out),
        .dst_q   (muxout_out)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed and randomized transactions against a latency model.
// Watchdog scenario runs only when built with MEM_TIMEOUT_EN.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ctlwb_in, ctlm_in;
    logic [31:0] alu_result_in, rdata2_in;
    logic [4:0]  muxout_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [1:0]  ctlwb_out;
    logic [31:0] read_data_out, alu_result_out;
    logic [4:0]  muxout_out;
    logic        mem_err;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DW(32), .TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctlwb_in       (ctlwb_in),
        .ctlm_in        (ctlm_in),
        .alu_result_in  (alu_result_in),
        .rdata2_in      (rdata2_in),
        .muxout_in      (muxout_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .stall          (stall),
        .ctlwb_out      (ctlwb_out),
        .read_data_out  (read_data_out),
        .alu_result_out (alu_result_out),
        .muxout_out     (muxout_out),
        .mem_err        (mem_err)
    );

    typedef struct {
        int          stalls;
        int          reqs;
        bit          stable;
        bit          bubble_ok;
        bit          err_seen;
        logic [1:0]  ctlwb;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  mux;
    } obs_t;

    typedef struct {
        int          stalls;
        int          reqs;
        logic [1:0]  ctlwb;
        logic [31:0] rdata;
    } exp_t;

    // Reference: stall and request counts follow directly from the memory latencies
    function automatic exp_t model(input logic [1:0] cwb, input logic [1:0] cm,
                                   input int rlat, input int vlat, input logic [31:0] rdat);
        exp_t e;
        bit acc  = (cm != 2'b00);
        bit load = cm[1];
        e.stalls = !acc ? 0 : (2 + rlat + (load ? vlat : 0));
        e.reqs   = acc ? (1 + rlat) : 0;
        e.ctlwb  = cwb;
        e.rdata  = load ? rdat : 32'h0;
        return e;
    endfunction

    // Drives one instruction and a responding memory; entered and left at #1 after a rising edge
    task automatic do_txn(input logic [1:0] cwb, input logic [1:0] cm, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [4:0] rd, input int rlat,
                          input int vlat, input logic [31:0] rdat, output obs_t o);
        int vcnt = -1;
        bit was_stall, acc_rdy;
        o.stalls = 0; o.reqs = 0; o.stable = 1; o.bubble_ok = 1; o.err_seen = 0;
        ctlwb_in = cwb; ctlm_in = cm; alu_result_in = alu; rdata2_in = wd; muxout_in = rd;
        for (int c = 0; c < 64; c++) begin
            dmem_ready  = dmem_req && (o.reqs >= rlat);
            if (cm[1]) dmem_rvalid = (dmem_ready && vlat == 0) || (vcnt == 0);
            else       dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata  = (cm[1] && dmem_rvalid) ? rdat : $urandom;
            #1;
            if (dmem_req) begin
                o.reqs++;
                if (dmem_we !== (cm == 2'b01) || dmem_addr !== alu || dmem_wdata !== wd) o.stable = 0;
            end
            was_stall = stall;
            acc_rdy   = dmem_ready && cm[1] && vlat > 0;
            if (stall) o.stalls++;
            @(posedge clk); #1;
            o.err_seen |= mem_err;
            if (was_stall && (ctlwb_out !== 2'b00 || read_data_out !== 32'h0 ||
                              alu_result_out !== 32'h0 || muxout_out !== 5'h0)) o.bubble_ok = 0;
            if (acc_rdy) vcnt = vlat - 1;
            else if (vcnt >= 0) vcnt--;
            if (!was_stall) break;
        end
        dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        o.ctlwb = ctlwb_out; o.rdata = read_data_out; o.alu = alu_result_out; o.mux = muxout_out;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ctlwb_in = 2'b11; ctlm_in = 2'b00; alu_result_in = 32'hFFFF_FFFF;
        rdata2_in = 32'h1; muxout_in = 5'h1F;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({ctlwb_out, read_data_out, alu_result_out, muxout_out} !== '0) begin
            failed++;
            $display("FAIL reset_outputs got ctlwb=%b rd=%h alu=%h mux=%h want all 0",
                     ctlwb_out, read_data_out, alu_result_out, muxout_out);
        end
        tests++;
        if (dmem_req !== 1'b0 || stall !== 1'b0 || mem_err !== 1'b0) begin
            failed++;
            $display("FAIL reset_ctrl got req=%b stall=%b err=%b want 0 0 0", dmem_req, stall, mem_err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_op;
        obs_t o;
        do_txn(2'b10, 2'b00, 32'h1234, 32'h5555, 5'd5, 0, 0, 32'h0, o);
        tests++;
        if (o.stalls !== 0) begin failed++; $display("FAIL alu_stall got %0d want 0", o.stalls); end
        tests++;
        if (o.ctlwb !== 2'b10 || o.alu !== 32'h1234 || o.mux !== 5'd5 || o.rdata !== 32'h0) begin
            failed++;
            $display("FAIL alu_wb got ctlwb=%b alu=%h mux=%0d rd=%h want 10 1234 5 0",
                     o.ctlwb, o.alu, o.mux, o.rdata);
        end
    endtask

    task automatic test_load;
        obs_t o;
        do_txn(2'b11, 2'b10, 32'h40, 32'h0, 5'd9, 0, 2, 32'hDEADBEEF, o);
        tests++;
        if (o.stalls !== 4) begin failed++; $display("FAIL load_stall got %0d want 4", o.stalls); end
        tests++;
        if (!o.bubble_ok) begin failed++; $display("FAIL load_bubble got nonzero MEM/WB want 0 during stall"); end
        tests++;
        if (o.rdata !== 32'hDEADBEEF || o.ctlwb !== 2'b11 || o.mux !== 5'd9) begin
            failed++;
            $display("FAIL load_wb got rd=%h ctlwb=%b mux=%0d want deadbeef 11 9", o.rdata, o.ctlwb, o.mux);
        end
    endtask

    task automatic test_store;
        obs_t o;
        do_txn(2'b00, 2'b01, 32'h80, 32'hA5A5A5A5, 5'd0, 2, 0, 32'h0, o);
        tests++;
        if (o.reqs !== 3 || !o.stable) begin
            failed++; $display("FAIL store_req got reqs=%0d stable=%0b want 3 1", o.reqs, o.stable);
        end
        tests++;
        if (o.stalls !== 4) begin failed++; $display("FAIL store_stall got %0d want 4", o.stalls); end
        tests++;
        if (o.ctlwb !== 2'b00 || o.rdata !== 32'h0 || o.alu !== 32'h80) begin
            failed++;
            $display("FAIL store_wb got ctlwb=%b rd=%h alu=%h want 00 0 80", o.ctlwb, o.rdata, o.alu);
        end
    endtask

    task automatic test_both_bits;
        obs_t o;
        do_txn(2'b11, 2'b11, 32'hC0, 32'h1111_2222, 5'd3, 1, 1, 32'hCAFE_F00D, o);
        tests++;
        if (!o.stable) begin failed++; $display("FAIL both_bits_we got stable=0 want we=0 held"); end
        tests++;
        if (o.stalls !== 4 || o.rdata !== 32'hCAFE_F00D) begin
            failed++;
            $display("FAIL both_bits_load got stalls=%0d rd=%h want 4 cafef00d", o.stalls, o.rdata);
        end
    endtask

    task automatic test_back_to_back;
        obs_t o;
        exp_t e;
        logic [1:0]  cwb, cm;
        logic [31:0] alu, wd, rdat;
        logic [4:0]  rd;
        int rlat, vlat;
        for (int n = 0; n < 40; n++) begin
            cwb = 2'($urandom); cm = 2'($urandom);
            alu = $urandom; wd = $urandom; rdat = $urandom; rd = 5'($urandom);
            rlat = $urandom_range(0, 3); vlat = $urandom_range(0, 3);
            e = model(cwb, cm, rlat, vlat, rdat);
            do_txn(cwb, cm, alu, wd, rd, rlat, vlat, rdat, o);
            tests++;
            if (o.stalls !== e.stalls || o.reqs !== e.reqs) begin
                failed++;
                $display("FAIL b2b_timing[%0d] got stalls=%0d reqs=%0d want %0d %0d",
                         n, o.stalls, o.reqs, e.stalls, e.reqs);
            end
            tests++;
            if (!o.stable || !o.bubble_ok || o.err_seen) begin
                failed++;
                $display("FAIL b2b_proto[%0d] got stable=%0b bubble_ok=%0b err=%0b want 1 1 0",
                         n, o.stable, o.bubble_ok, o.err_seen);
            end
            tests++;
            if (o.ctlwb !== e.ctlwb || o.rdata !== e.rdata || o.alu !== alu || o.mux !== rd) begin
                failed++;
                $display("FAIL b2b_wb[%0d] got %b %h %h %0d want %b %h %h %0d", n,
                         o.ctlwb, o.rdata, o.alu, o.mux, e.ctlwb, e.rdata, alu, rd);
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        ctlwb_in = 2'b11; ctlm_in = 2'b10; alu_result_in = 32'h44; muxout_in = 5'd7;
        @(posedge clk); #1;
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        tests++;
        if (stall !== 1'b1 || dmem_req !== 1'b0) begin
            failed++; $display("FAIL wait_entry got stall=%b req=%b want 1 0", stall, dmem_req);
        end
        rst_n = 1'b0; ctlm_in = 2'b00; ctlwb_in = 2'b00;
        @(posedge clk); #1;
        tests++;
        if (stall !== 1'b0 || dmem_req !== 1'b0 ||
            {ctlwb_out, read_data_out, alu_result_out, muxout_out} !== '0) begin
            failed++;
            $display("FAIL mid_reset got stall=%b req=%b ctlwb=%b rd=%h want 0 0 00 0",
                     stall, dmem_req, ctlwb_out, read_data_out);
        end
        rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        tests++;
        if (stall !== 1'b0 || dmem_req !== 1'b0 || read_data_out !== 32'h0) begin
            failed++;
            $display("FAIL late_rvalid got stall=%b req=%b rd=%h want 0 0 0", stall, dmem_req, read_data_out);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        int reqs = 0;
        int errs = 0;
        ctlwb_in = 2'b11; ctlm_in = 2'b10; alu_result_in = 32'h100; muxout_in = 5'd2;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        for (int c = 0; c < 20 && errs == 0; c++) begin
            if (dmem_req) reqs++;
            @(posedge clk); #1;
            if (mem_err) errs++;
        end
        ctlm_in = 2'b00;
        @(posedge clk); #1;
        if (mem_err) errs++;
        tests++;
        if (reqs !== 4 || errs !== 1) begin
            failed++; $display("FAIL timeout_err got reqs=%0d pulses=%0d want 4 1", reqs, errs);
        end
        tests++;
        if (ctlwb_out !== 2'b00 || read_data_out !== 32'h0 || stall !== 1'b0) begin
            failed++;
            $display("FAIL timeout_wb got ctlwb=%b rd=%h stall=%b want 00 0 0", ctlwb_out, read_data_out, stall);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_both_bits();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
